// File: rtl/if_prefetch_buffer_pkg.sv
// Shared constants for the instruction prefetch buffer: decode NOP, PC step and sizing helper.
package if_prefetch_buffer_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;
  localparam int          PC_STEP   = 4;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry {pc, instr} circular buffer with push, pop and flush; head entry visible combinationally.
module fetch_fifo
  import if_prefetch_buffer_pkg::*;
#(
  parameter int BUS_WIDTH   = 64,
  parameter int INSTR_WIDTH = 32,
  parameter int DEPTH       = 4,
  localparam int PTR_W      = $clog2(DEPTH),
  localparam int CNT_W      = cnt_width(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic [BUS_WIDTH-1:0]   push_pc,
  input  logic [INSTR_WIDTH-1:0] push_instr,
  input  logic                   pop,
  output logic [CNT_W-1:0]       count,
  output logic                   empty,
  output logic [BUS_WIDTH-1:0]   head_pc,
  output logic [INSTR_WIDTH-1:0] head_instr
);

  logic [BUS_WIDTH-1:0]   pc_mem    [DEPTH];
  logic [INSTR_WIDTH-1:0] instr_mem [DEPTH];
  logic [PTR_W-1:0]       rd_ptr;
  logic [PTR_W-1:0]       wr_ptr;
  logic                   do_push;
  logic                   do_pop;
  logic                   full;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_push = push & ~flush;
  assign do_pop  = pop & ~flush & ~empty;

  // Flush dominates; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      pc_mem[wr_ptr]    <= push_pc;
      instr_mem[wr_ptr] <= push_instr;
    end
  end

  assign head_pc    = pc_mem[rd_ptr];
  assign head_instr = instr_mem[rd_ptr];

  no_push_when_full: assert property (@(posedge clk) disable iff (rst) !(do_push && full));

endmodule

// File: rtl/if_prefetch_buffer.sv
// Instruction prefetch queue between imem and IF/ID: credit-based sequential fetch, redirect flush.
// Optional PREFETCH_BYPASS_EN forwards a response straight to out_* when the queue is empty.
module if_prefetch_buffer
  import if_prefetch_buffer_pkg::*;
#(
  parameter int                   BUS_WIDTH     = 64,
  parameter int                   INSTR_WIDTH   = 32,
  parameter int                   INSTR_MEM_LEN = 15,
  parameter int                   DEPTH         = 4,
  parameter logic [BUS_WIDTH-1:0] RESET_PC      = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall,
  input  logic                     redirect,
  input  logic [BUS_WIDTH-1:0]     redirect_pc,
  output logic                     imem_req,
  output logic [INSTR_MEM_LEN-1:0] imem_addr,
  input  logic [INSTR_WIDTH-1:0]   imem_rdata,
  output logic                     out_valid,
  output logic [BUS_WIDTH-1:0]     out_pc,
  output logic [INSTR_WIDTH-1:0]   out_instr
);

  localparam int CNT_W = cnt_width(DEPTH);
  localparam int INF_W = CNT_W + 1;

  logic [BUS_WIDTH-1:0]   fetch_pc;
  logic [BUS_WIDTH-1:0]   resp_pc_p1;
  logic                   resp_vld_p1;
  logic [BUS_WIDTH-1:0]   last_pc;
  logic [CNT_W-1:0]       count;
  logic                   fifo_empty;
  logic [BUS_WIDTH-1:0]   head_pc;
  logic [INSTR_WIDTH-1:0] head_instr;
  logic                   live_resp;
  logic                   bypass;
  logic                   pop;
  logic                   fifo_push;
  logic                   fifo_pop;
  logic [INF_W-1:0]       inflight;

  assign live_resp = resp_vld_p1 & ~redirect;

`ifdef PREFETCH_BYPASS_EN
  assign bypass = fifo_empty & live_resp;
`else
  assign bypass = 1'b0;
`endif

  assign out_valid = ~fifo_empty | bypass;
  assign pop       = out_valid & ~stall & ~redirect;
  assign fifo_push = live_resp & ~(bypass & pop);
  assign fifo_pop  = pop & ~bypass;

  // Entries held plus the one in flight, less this cycle's pop, must leave room for a new request.
  assign inflight = INF_W'(count) + INF_W'(resp_vld_p1) - INF_W'(pop);
  assign imem_req = ~rst & ~redirect & (inflight < INF_W'(DEPTH));
  assign imem_addr = fetch_pc[INSTR_MEM_LEN+1:2];

  assign out_pc    = ~fifo_empty ? head_pc    : (bypass ? resp_pc_p1 : last_pc);
  assign out_instr = ~fifo_empty ? head_instr : (bypass ? imem_rdata : INSTR_WIDTH'(NOP_INSTR));

  // Stage p0 -> p1: request issued, response expected next cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      resp_vld_p1 <= 1'b0;
      resp_pc_p1  <= '0;
      last_pc     <= '0;
    end else begin
      if (redirect)      fetch_pc <= redirect_pc & ~BUS_WIDTH'(3);
      else if (imem_req) fetch_pc <= fetch_pc + BUS_WIDTH'(PC_STEP);
      resp_vld_p1 <= imem_req;
      if (imem_req)  resp_pc_p1 <= fetch_pc;
      if (out_valid) last_pc    <= out_pc;
    end
  end

  fetch_fifo #(
    .BUS_WIDTH  (BUS_WIDTH),
    .INSTR_WIDTH(INSTR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .push      (fifo_push),
    .push_pc   (resp_pc_p1),
    .push_instr(imem_rdata),
    .pop       (fifo_pop),
    .count     (count),
    .empty     (fifo_empty),
    .head_pc   (head_pc),
    .head_instr(head_instr)
  );

endmodule

// File: tb/tb_if_prefetch_buffer.sv
// Directed bench for if_prefetch_buffer; imem model returns the word index as instruction.
module tb_if_prefetch_buffer;

  localparam logic [31:0] NOP = 32'h00000013;
`ifdef PREFETCH_BYPASS_EN
  localparam int LAT  = 1;
  localparam int RLAT = 2;
`else
  localparam int LAT  = 2;
  localparam int RLAT = 3;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        imem_req;
  logic [14:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        out_valid;
  logic [63:0] out_pc;
  logic [31:0] out_instr;

  int tests = 0;
  int fails = 0;

  if_prefetch_buffer dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .out_valid  (out_valid),
    .out_pc     (out_pc),
    .out_instr  (out_instr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (imem_req) imem_rdata <= {17'd0, imem_addr};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    #2;
    for (int i = 0; i < 2; i++) begin
      tests++;
      if (imem_req !== 1'b0) begin fails++; $display("FAIL reset_req: got %b exp 0", imem_req); end
      tests++;
      if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b exp 0", out_valid); end
      tests++;
      if (out_pc !== 64'h0) begin fails++; $display("FAIL reset_pc: got %h exp 0", out_pc); end
      tests++;
      if (out_instr !== NOP) begin fails++; $display("FAIL reset_instr: got %h exp %h", out_instr, NOP); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_stream();
    do_reset();
    tests++;
    if (imem_req !== 1'b1 || imem_addr !== 15'h0) begin
      fails++; $display("FAIL stream_first_req: got req=%b addr=%h exp req=1 addr=0", imem_req, imem_addr);
    end
    for (int c = 1; c <= LAT + 7; c++) begin
      @(negedge clk);
      tests++;
      if (c < LAT) begin
        if (out_valid !== 1'b0) begin fails++; $display("FAIL stream_early c=%0d: got valid=%b exp 0", c, out_valid); end
      end else if (out_valid !== 1'b1 || out_pc !== 64'(4 * (c - LAT)) || out_instr !== 32'(c - LAT)) begin
        fails++;
        $display("FAIL stream c=%0d: got v=%b pc=%h instr=%h exp v=1 pc=%h instr=%h",
                 c, out_valid, out_pc, out_instr, 4 * (c - LAT), c - LAT);
      end
    end
  endtask

  task automatic test_stall();
    int bad;
    do_reset();
    repeat (LAT) @(negedge clk);
    tests++;
    if (out_valid !== 1'b1 || out_pc !== 64'h0) begin
      fails++; $display("FAIL stall_first: got v=%b pc=%h exp v=1 pc=0", out_valid, out_pc);
    end
    stall = 1'b1;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_pc !== 64'h0) bad++;
    end
    tests++;
    if (bad != 0) begin fails++; $display("FAIL stall_hold: got %0d bad cycles exp 0", bad); end
    tests++;
    if (imem_req !== 1'b0 || imem_addr !== 15'h4) begin
      fails++; $display("FAIL stall_full: got req=%b addr=%h exp req=0 addr=4", imem_req, imem_addr);
    end
    stall = 1'b0;
    #1;
    for (int k = 0; k < 8; k++) begin
      tests++;
      if (out_valid !== 1'b1 || out_pc !== 64'(4 * k) || out_instr !== 32'(k)) begin
        fails++;
        $display("FAIL stall_release k=%0d: got v=%b pc=%h instr=%h exp v=1 pc=%h instr=%h",
                 k, out_valid, out_pc, out_instr, 4 * k, k);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_redirect_full();
    do_reset();
    repeat (LAT) @(negedge clk);
    stall = 1'b1;
    repeat (2) @(negedge clk);
    redirect = 1'b1; redirect_pc = 64'h100;
    #1;
    tests++;
    if (imem_req !== 1'b0) begin fails++; $display("FAIL redir_req_n: got %b exp 0", imem_req); end
    @(negedge clk);
    redirect = 1'b0; stall = 1'b0;
    #1;
    tests++;
    if (imem_req !== 1'b1 || imem_addr !== 15'h40) begin
      fails++; $display("FAIL redir_req_n1: got req=%b addr=%h exp req=1 addr=40", imem_req, imem_addr);
    end
    for (int c = 1; c <= RLAT + 1; c++) begin
      if (c > 1) begin @(negedge clk); #1; end
      tests++;
      if (c < RLAT) begin
        if (out_valid !== 1'b0) begin fails++; $display("FAIL redir_stale c=%0d: got v=%b pc=%h exp v=0", c, out_valid, out_pc); end
      end else if (out_valid !== 1'b1 || out_pc !== 64'h100 + 64'(4 * (c - RLAT)) || out_instr !== 32'h40 + 32'(c - RLAT)) begin
        fails++;
        $display("FAIL redir_target c=%0d: got v=%b pc=%h instr=%h exp v=1 pc=%h instr=%h",
                 c, out_valid, out_pc, out_instr, 'h100 + 4 * (c - RLAT), 'h40 + c - RLAT);
      end
    end
  endtask

  task automatic test_redirect_align();
    do_reset();
    @(negedge clk);
    redirect = 1'b1; redirect_pc = 64'h203;
    @(negedge clk);
    redirect = 1'b0;
    #1;
    tests++;
    if (imem_req !== 1'b1 || imem_addr !== 15'h80) begin
      fails++; $display("FAIL align_addr: got req=%b addr=%h exp req=1 addr=80", imem_req, imem_addr);
    end
    repeat (RLAT - 1) @(negedge clk);
    tests++;
    if (out_valid !== 1'b1 || out_pc !== 64'h200 || out_instr !== 32'h80) begin
      fails++; $display("FAIL align_out: got v=%b pc=%h instr=%h exp v=1 pc=200 instr=80", out_valid, out_pc, out_instr);
    end
  endtask

  task automatic test_flush_wins();
    do_reset();
    repeat (LAT + 2) @(negedge clk);
    tests++;
    if (out_valid !== 1'b1 || out_pc !== 64'h8) begin
      fails++; $display("FAIL flush_pre: got v=%b pc=%h exp v=1 pc=8", out_valid, out_pc);
    end
    stall = 1'b1; redirect = 1'b1; redirect_pc = 64'h300;
    @(negedge clk);
    stall = 1'b0; redirect = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || out_instr !== NOP || out_pc !== 64'h8) begin
      fails++; $display("FAIL flush_wins: got v=%b pc=%h instr=%h exp v=0 pc=8 instr=%h", out_valid, out_pc, out_instr, NOP);
    end
    repeat (RLAT - 1) @(negedge clk);
    tests++;
    if (out_valid !== 1'b1 || out_pc !== 64'h300 || out_instr !== 32'hC0) begin
      fails++; $display("FAIL flush_target: got v=%b pc=%h instr=%h exp v=1 pc=300 instr=c0", out_valid, out_pc, out_instr);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    repeat (LAT + 3) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    tests++;
    if (out_valid !== 1'b0 || imem_req !== 1'b0 || out_pc !== 64'h0 || out_instr !== NOP) begin
      fails++; $display("FAIL async_rst: got v=%b req=%b pc=%h instr=%h exp v=0 req=0 pc=0 instr=%h",
                        out_valid, imem_req, out_pc, out_instr, NOP);
    end
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    tests++;
    if (imem_req !== 1'b1 || imem_addr !== 15'h0) begin
      fails++; $display("FAIL async_restart_req: got req=%b addr=%h exp req=1 addr=0", imem_req, imem_addr);
    end
    repeat (LAT + 1) @(negedge clk);
    tests++;
    if (out_valid !== 1'b1 || out_pc !== 64'h0 || out_instr !== 32'h0) begin
      fails++; $display("FAIL async_restart_out: got v=%b pc=%h instr=%h exp v=1 pc=0 instr=0", out_valid, out_pc, out_instr);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_full();
    test_redirect_align();
    test_flush_wins();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
